draw_bird: RTL and testbench

DRAW_BIRD -- requirements
Module: draw_bird

---
 rtl/draw_bird.sv | 107 ++++++++++
 tb/tb_draw_bird.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_bird.sv
// Sprite redraw engine: per frame it erases the 4x4 bird at its previous row,
// then plots it at the newly latched row, one pixel per clock.
module draw_bird #(
   parameter logic [7:0] BIRD_X      = 8'd20,
   parameter logic [2:0] BIRD_COLOUR = 3'b110,
   parameter logic [2:0] BG_COLOUR   = 3'b000,
   parameter logic [6:0] Y_MAX       = 7'd119
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       go,
   input  logic [7:0] bird_y,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done,
   output logic [2:0] state_dbg
);

   // Handshake: go is a level request sampled only while IDLE (busy=0); once
   // taken, busy stays high until the cycle after the one-cycle done pulse.
   // x_out/y_out/colour are meaningful only while plot=1.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      ERASE = 3'd2,
      DRAW  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [7:0] Y_LIM = {1'b0, Y_MAX} - 8'd3;

   state_t     state, state_nxt;
   logic [3:0] cnt;
   logic [6:0] old_y, new_y;
   logic       valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = LATCH;
         LATCH:   state_nxt = valid ? ERASE : DRAW;
         ERASE:   if (cnt == 4'd15) state_nxt = DRAW;
         DRAW:    if (cnt == 4'd15) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Clamp on the full 8-bit input so large values saturate rather than wrap.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= 4'd0;
         old_y <= 7'd0;
         new_y <= 7'd0;
         valid <= 1'b0;
      end else begin
         case (state)
            LATCH: begin
               cnt   <= 4'd0;
               new_y <= (bird_y > Y_LIM) ? Y_LIM[6:0] : bird_y[6:0];
            end
            ERASE, DRAW: cnt <= cnt + 4'd1;
            DONE: begin
               old_y <= new_y;
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      plot   = 1'b0;
      x_out  = 8'd0;
      y_out  = 7'd0;
      colour = 3'd0;
      done   = 1'b0;
      busy   = (state != IDLE);
      case (state)
         ERASE: begin
            plot   = 1'b1;
            x_out  = BIRD_X + {6'd0, cnt[1:0]};
            y_out  = old_y + {5'd0, cnt[3:2]};
            colour = BG_COLOUR;
         end
         DRAW: begin
            plot   = 1'b1;
            x_out  = BIRD_X + {6'd0, cnt[1:0]};
            y_out  = new_y + {5'd0, cnt[3:2]};
            colour = BIRD_COLOUR;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_draw_bird.sv
// Randomised scoreboard bench for draw_bird: a frame-level model pushes the
// expected pixel stream and done cycle; a negedge monitor pops and compares.
module tb_draw_bird;

   localparam int BIRD_X = 20;
   localparam int Y_MAX  = 119;

   logic       clk;
   logic       resetn;
   logic       go;
   logic [7:0] bird_y;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;
   logic [2:0] state_dbg;

   draw_bird dut (
      .clk       (clk),
      .resetn    (resetn),
      .go        (go),
      .bird_y    (bird_y),
      .x_out     (x_out),
      .y_out     (y_out),
      .colour    (colour),
      .plot      (plot),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard state: word = {done, x, y, colour}
   logic [18:0] exp_q[$];
   int          done_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;

   // frame-level reference model
   int m_old_y   = 0;
   bit m_valid   = 0;
   int last_done = 0;

   task automatic push_pix(input int x, input int y, input int c);
      logic [18:0] w;
      w = {1'b0, 8'(x), 7'(y), 3'(c)};
      exp_q.push_back(w);
   endtask

   task automatic model_frame(input int y, input int kk);
      int ny;
      logic [18:0] w;
      ny = (y > Y_MAX - 3) ? Y_MAX - 3 : y;
      if (m_valid)
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) push_pix(BIRD_X + c, m_old_y + r, 0);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) push_pix(BIRD_X + c, ny + r, 6);
      w = 19'd0;
      w[18] = 1'b1;
      exp_q.push_back(w);
      last_done = kk + (m_valid ? 33 : 17);
      done_q.push_back(last_done);
      m_old_y = ny;
      m_valid = 1'b1;
   endtask

   // monitor
   always @(negedge clk) begin
      logic [18:0] e, a;
      int ed;
      if (resetn) begin
         if (plot || done) begin
            a = {done, x_out, y_out, colour};
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got %h, queue empty", a);
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  n_fail++;
                  $display("FAIL pixel: got %h expected %h at cyc %0d", a, e, cyc);
               end
            end
            if (plot) begin
               n_cmp++;
               if (int'(y_out) > Y_MAX) begin
                  n_fail++;
                  $display("FAIL y_range: got %0d, limit %0d", y_out, Y_MAX);
               end
            end
            if (done) begin
               n_cmp++;
               if (done_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL done_cycle: got %0d, none expected", cyc);
               end else begin
                  ed = done_q.pop_front();
                  if (cyc != ed) begin
                     n_fail++;
                     $display("FAIL done_cycle: got %0d expected %0d", cyc, ed);
                  end
               end
            end
         end else begin
            n_cmp++;
            if ({x_out, y_out, colour} !== 18'd0) begin
               n_fail++;
               $display("FAIL idle_zero: got x=%0d y=%0d c=%0d expected 0", x_out, y_out, colour);
            end
         end
      end
   end

   // driver tasks
   task automatic start_frame(input logic [7:0] y, input bit keep_go);
      @(negedge clk);
      bird_y = y;
      go     = 1'b1;
      model_frame(int'(y), cyc + 1);
      @(negedge clk);
      if (!keep_go) go = 1'b0;
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      do begin
         @(negedge clk);
         budget++;
      end while ((busy || exp_q.size() != 0) && budget < 200);
      n_cmp++;
      if (budget >= 200) begin
         n_fail++;
         $display("FAIL wait_idle: busy=%0b pending=%0d after timeout, expected idle", busy, exp_q.size());
         exp_q.delete();
         done_q.delete();
      end
   endtask

   task automatic check_quiet(input string name);
      n_cmp++;
      if ({plot, busy, done, x_out, y_out, colour} !== 21'd0) begin
         n_fail++;
         $display("FAIL %s: got plot=%0b busy=%0b done=%0b x=%0d y=%0d c=%0d expected all 0",
                  name, plot, busy, done, x_out, y_out, colour);
      end
   endtask

   initial begin
      int budget;
      resetn = 1'b0;
      go     = 1'b0;
      bird_y = 8'd0;
      repeat (3) @(negedge clk);
      check_quiet("reset_state");
      resetn = 1'b1;
      @(negedge clk);
      check_quiet("idle_after_reset");

      // first frame: draw only
      start_frame(8'd64, 0);
      wait_idle();
      // second frame: erase 64, draw 70
      start_frame(8'd70, 0);
      wait_idle();
      // clamp
      start_frame(8'd200, 0);
      wait_idle();
      // same row: full erase and redraw
      start_frame(8'd116, 0);
      wait_idle();

      // go held high: next frame only after returning to IDLE
      start_frame(8'd40, 1);
      budget = 0;
      while (cyc != last_done + 1 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL held_go_idle: busy=%0b expected 0", busy);
      end
      model_frame(int'(bird_y), cyc + 1);
      @(negedge clk);
      go = 1'b0;
      wait_idle();

      // bird_y changed during DRAW
      start_frame(8'd30, 0);
      repeat (20) @(negedge clk);
      bird_y = 8'd10;
      wait_idle();
      start_frame(8'd10, 0);
      wait_idle();

      // reset during ERASE
      start_frame(8'd50, 0);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 resetn = 1'b0;
      exp_q.delete();
      done_q.delete();
      m_valid = 1'b0;
      m_old_y = 0;
      #1 check_quiet("reset_mid_frame");
      repeat (2) @(negedge clk);
      check_quiet("reset_held");
      resetn = 1'b1;
      start_frame(8'd60, 0);
      wait_idle();

      // randomised frames with random gaps and post-latch bird_y changes
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         start_frame(8'($urandom_range(0, 255)), 0);
         @(negedge clk);
         bird_y = 8'($urandom_range(0, 255));
         wait_idle();
      end

      n_cmp++;
      if (done_q.size() != 0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pixels %0d dones pending, expected 0", exp_q.size(), done_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
